ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Iterative RV32M multiply/divide sequencer attached to the EX stage.
//  - Accepts a start pulse and forwarded rs1/rs2 values from EX.
//  - Holds the pipeline through stall while it iterates.
//  - Returns a 32-bit result with a one-cycle done pulse, at the moment EX releases the instruction to ex_mem.
// PARAMETERS
//  XLEN     32  operand/result width
//  CNT_W    5   iteration counter width; covers XLEN iterations
// PORTS
//  clk      in   1     clock, rising edge
//  rst      in   1     reset, asynchronous, active-high
//  start    in   1     EX holds a valid M-extension op (opcode op_b_reg, funct7 0000001)
//  funct3   in   3     muldiv_f3_t op select
//  rs1_v    in   XLEN  forwarded operand A
//  rs2_v    in   XLEN  forwarded operand B
//  flush    in   1     EX instruction squashed (branch/jump redirect)
//  stall    out  1     freeze PC, if_id and id_ex this cycle
//  done     out  1     result valid this cycle; EX captures into ex_mem.aluout
//  result   out  XLEN  op result; 0 when done=0
// BEHAVIOUR
//  Reset: state=IDLE, count=0, all internal regs=0, stall=0, done=0, result=0.
//  States: IDLE, CALC, DONE (muldiv_state_t).
//  IDLE:
//   - stall = start & ~flush (combinational).
//   - start & ~flush latches the operands and funct3.
//   - Signed ops latch |operand|, plus neg_res and neg_rem flags.
//   - DIV/REM special case goes to DONE; all others go to CALC with count=0.
//  CALC: stall=1, one iteration per cycle.
//   - count==XLEN-1 -> DONE.
//   - Multiply: radix-2 shift-add into a 2*XLEN product register.
//   - Divide: restoring shift-subtract; remainder XLEN+1 bits.
//  DONE:
//   - stall=0, done=1 for exactly one cycle, result driven; next state IDLE.
//   - start is ignored in DONE. The same instruction leaves EX this cycle; the next op starts in IDLE.
//  Latency: start sampled at edge N -> CALC for edges N+1..N+32 -> done=1 in the cycle after edge N+32. Total 34 cycles of EX occupancy. Special case: done in the cycle after edge N.
//  Results (mul_hi/lo = product bits [63:32]/[31:0] after sign fix):
//   - MUL -> lo; MULH, MULHSU, MULHU -> hi.
//   - MULHSU: only rs1 is treated as signed.
//   - DIV/DIVU -> quotient; REM/REMU -> remainder.
//   - Quotient is negated if the operand signs differ (signed ops). Remainder takes the sign of the dividend.
//  Special cases (no iteration):
//   - rs2==0: quotient=32'hFFFF_FFFF, remainder=rs1.
//   - DIV/REM with rs1=32'h8000_0000, rs2=32'hFFFF_FFFF: quotient=32'h8000_0000, remainder=0.
//  flush: synchronous abort from any state to IDLE on the next edge. done is forced 0 that cycle, stall=0. Partial state is discarded.
//  rst mid-operation: immediate return to IDLE with reset values; no done is produced.
//  Operands are sampled only in IDLE; forwarding changes during CALC are ignored.
//  All arithmetic is unsigned on magnitudes; sign applied once in DONE.
// STRUCTURE
//  rv32i_types gains:
//   - muldiv_f3_t: mul=000, mulh=001, mulhsu=010, mulhu=011, div=100, divu=101, rem=110, remu=111.
//   - muldiv_state_t {IDLE, CALC, DONE}.
//   - localparam funct7_muldiv = 7'b0000001.
//  One sub-module, muldiv_iter: the per-cycle shift-add/shift-subtract step, fully combinational.
//  FSM, counter, sign fix-up and special-case detection stay in this module.
// TESTING
//  1. MUL 7 * -3 (rs2=32'hFFFF_FFFD) -> stall high 33 cycles; done in cycle 34 with result=32'hFFFF_FFEB.
//  2. MULHU 32'hFFFF_FFFF * 32'hFFFF_FFFF -> result=32'hFFFF_FFFE. MULH with the same operands -> 0. MULHSU -1 * 2 -> 32'hFFFF_FFFF.
//  3. DIV -20 / 6 -> 32'hFFFF_FFFD. REM -20 / 6 -> 32'hFFFF_FFFE. DIVU 100 / 7 -> 14. REMU 100 / 7 -> 2.
//  4. DIV 5 / 0 -> done 1 cycle after start, result=32'hFFFF_FFFF. REM 5 / 0 -> 5. DIV 32'h8000_0000 / -1 -> 32'h8000_0000. REM of the same -> 0.
//  5. flush asserted at CALC iteration 10 -> next cycle IDLE, stall=0, no done pulse. A fresh start then completes with the correct value.
//  6. rst pulsed mid-CALC, then released -> all outputs 0, state IDLE. Back-to-back MUL then DIV give independent correct results. Operand change during CALC does not alter the result.

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types and constants for the EX-stage RV32M multiply/divide sequencer.
package ex_muldiv_unit_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 5;

    localparam logic [6:0]      funct7_muldiv = 7'b0000001;
    localparam logic [XLEN-1:0] xlen_min      = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        mul    = 3'b000,
        mulh   = 3'b001,
        mulhsu = 3'b010,
        mulhu  = 3'b011,
        div    = 3'b100,
        divu   = 3'b101,
        rem    = 3'b110,
        remu   = 3'b111
    } muldiv_f3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// EX <-> muldiv sequencer signal bundle.
interface ex_muldiv_unit_if;
    import ex_muldiv_unit_pkg::*;

    // Handshake: EX holds start with stable funct3/operands while stall is high;
    // the op completes in the single cycle where done=1 (stall=0 then), and flush
    // cancels whatever is in flight without a done pulse.
    logic                start;
    muldiv_f3_t          funct3;
    logic [XLEN-1:0]     rs1_v;
    logic [XLEN-1:0]     rs2_v;
    logic                flush;
    logic                stall;
    logic                done;
    logic [XLEN-1:0]     result;
    muldiv_state_t       dbg_state;

    modport master (
        output start, funct3, rs1_v, rs2_v, flush,
        input  stall, done, result, dbg_state
    );

    modport slave (
        input  start, funct3, rs1_v, rs2_v, flush,
        output stall, done, result, dbg_state
    );

endinterface

// File: rtl/ex_muldiv_unit_iter.sv
// One radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
module ex_muldiv_unit_iter
    import ex_muldiv_unit_pkg::*;
(
    input  logic                is_div,
    input  logic [2*XLEN-1:0]   prod,
    input  logic [XLEN:0]       rem,
    input  logic [XLEN-1:0]     opnd,
    output logic [2*XLEN-1:0]   prod_next,
    output logic [XLEN:0]       rem_next
);

    logic [XLEN:0]   sum;
    logic [XLEN+1:0] shifted;
    logic [XLEN:0]   diff;
    logic            ge;

    always_comb begin
        sum       = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opnd} : '0);
        shifted   = {rem, prod[XLEN-1]};
        ge        = shifted >= {2'b00, opnd};
        diff      = shifted[XLEN:0] - {1'b0, opnd};
        prod_next = {sum, prod[XLEN-1:1]};
        rem_next  = rem;
        // For divide the low half holds the dividend shifting out and the quotient shifting in.
        if (is_div) begin
            prod_next = {prod[2*XLEN-1:XLEN], prod[XLEN-2:0], ge};
            rem_next  = ge ? diff : shifted[XLEN:0];
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide sequencer; stalls EX while iterating on operand magnitudes.
module ex_muldiv_unit
    import ex_muldiv_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    ex_muldiv_unit_if.slave bus
);

    muldiv_state_t      state_q;
    logic [CNT_W-1:0]   count_q;
    muldiv_f3_t         f3_q;
    logic [2*XLEN-1:0]  prod_q, prod_nx;
    logic [XLEN:0]      rem_q, rem_nx;
    logic [XLEN-1:0]    opnd_q, spec_res_q;
    logic               neg_res_q, neg_rem_q, special_q;

    logic               is_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]    a_mag, b_mag, spec_val;

    always_comb begin
        is_div   = bus.funct3[2];
        a_sgn    = bus.funct3 inside {mul, mulh, mulhsu, div, rem};
        b_sgn    = bus.funct3 inside {mul, mulh, div, rem};
        a_neg    = a_sgn & bus.rs1_v[XLEN-1];
        b_neg    = b_sgn & bus.rs2_v[XLEN-1];
        a_mag    = a_neg ? -bus.rs1_v : bus.rs1_v;
        b_mag    = b_neg ? -bus.rs2_v : bus.rs2_v;
        div_zero = is_div && (bus.rs2_v == '0);
        div_ovf  = (bus.funct3 inside {div, rem}) && (bus.rs1_v == xlen_min) && (bus.rs2_v == '1);
        // funct3[1] separates the remainder ops from the quotient ops.
        if (div_zero) spec_val = bus.funct3[1] ? bus.rs1_v : '1;
        else          spec_val = bus.funct3[1] ? '0 : xlen_min;
    end

    ex_muldiv_unit_iter u_muldiv_iter (
        .is_div    (f3_q[2]),
        .prod      (prod_q),
        .rem       (rem_q),
        .opnd      (opnd_q),
        .prod_next (prod_nx),
        .rem_next  (rem_nx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            f3_q       <= mul;
            prod_q     <= '0;
            rem_q      <= '0;
            opnd_q     <= '0;
            spec_res_q <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            special_q  <= 1'b0;
        end else if (bus.flush) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.start) begin
                    f3_q       <= bus.funct3;
                    prod_q     <= {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
                    opnd_q     <= is_div ? b_mag : a_mag;
                    rem_q      <= '0;
                    neg_res_q  <= a_neg ^ b_neg;
                    neg_rem_q  <= a_neg;
                    special_q  <= div_zero | div_ovf;
                    spec_res_q <= spec_val;
                    count_q    <= '0;
                    state_q    <= (div_zero | div_ovf) ? DONE : CALC;
                end
                CALC: begin
                    prod_q <= prod_nx;
                    rem_q  <= rem_nx;
                    if (count_q == CNT_W'(XLEN-1)) state_q <= DONE;
                    else                          count_q <= count_q + 1'b1;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, res_sel;

    always_comb begin
        prod_fix = neg_res_q ? -prod_q : prod_q;
        quo_fix  = neg_res_q ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
        rem_fix  = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        case (f3_q)
            mul:                  res_sel = prod_fix[XLEN-1:0];
            mulh, mulhsu, mulhu:  res_sel = prod_fix[2*XLEN-1:XLEN];
            div, divu:            res_sel = quo_fix;
            default:              res_sel = rem_fix;
        endcase
        if (special_q) res_sel = spec_res_q;
    end

    assign bus.stall     = ~bus.flush & (((state_q == IDLE) & bus.start) | (state_q == CALC));
    assign bus.done      = (state_q == DONE) & ~bus.flush;
    assign bus.result    = bus.done ? res_sel : '0;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Randomized + directed bench for ex_muldiv_unit against an arithmetic reference model.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_muldiv_unit_if bus();

  ex_muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [XLEN-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input muldiv_f3_t f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic        ovf;
    int          sa, sb;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    ea  = (f3 == mulhu) ? {32'b0, a} : {{32{a[31]}}, a};
    eb  = (f3 == mulhu || f3 == mulhsu) ? {32'b0, b} : {{32{b[31]}}, b};
    p   = ea * eb;
    case (f3)
      mul:    return p[31:0];
      mulh, mulhsu, mulhu: return p[63:32];
      div:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      rem:    return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      divu:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input muldiv_f3_t f3, input logic [31:0] a, input logic [31:0] b);
    return (f3[2] && b == 0) || ((f3 == div || f3 == rem) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // compare process: every done pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.done) begin
        check("done_stall", 32'(bus.stall), 32'h0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got result %h want no done", bus.result);
        end else begin
          check("result", bus.result, exp_q.pop_front());
        end
      end else if (bus.result !== '0) begin
        check("result_idle", bus.result, 32'h0);
      end
    end
  end

  task automatic drive_idle();
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = mul;
    bus.rs1_v  = '0;
    bus.rs2_v  = '0;
  endtask

  task automatic run_op(input muldiv_f3_t f3, input logic [31:0] a, input logic [31:0] b, input bit scramble);
    int lat, stalls, exp_lat;
    exp_lat = is_special(f3, a, b) ? 2 : 34;
    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.rs1_v  = a;
    bus.rs2_v  = b;
    exp_q.push_back(model(f3, a, b));
    lat    = 0;
    stalls = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.done) begin
        lat = c;
        break;
      end
      if (bus.stall) stalls++;
      @(posedge clk); #1;
      if (scramble) begin
        bus.rs1_v = $urandom;
        bus.rs2_v = $urandom;
      end
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("stall_cycles", 32'(stalls), 32'(exp_lat - 1));
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (lat == 0) exp_q.delete();
  endtask

  muldiv_f3_t  d_f3[14] = '{mul, mulhu, mulh, mulhsu, div, rem, divu, remu,
                            div, rem, div, rem, divu, remu};
  logic [31:0] d_a[14]  = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd100, 32'd100,
                            32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd5};
  logic [31:0] d_b[14]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2,
                            32'd6, 32'd6, 32'd7, 32'd7,
                            32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
  logic [31:0] d_exp[14] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF,
                             32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd14, 32'd2,
                             32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'd5};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(bus.stall), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_result", bus.result, 32'h0);
    check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0;

    // directed cases, each also pinning the model to a hand-computed value
    for (int i = 0; i < 14; i++) begin
      check($sformatf("pin_%0d", i), model(d_f3[i], d_a[i], d_b[i]), d_exp[i]);
      run_op(d_f3[i], d_a[i], d_b[i], 1'b0);
    end

    // flush at CALC iteration 10
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = mul; bus.rs1_v = 32'd123; bus.rs2_v = 32'd456;
    repeat (11) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    check("flush_stall", 32'(bus.stall), 32'h0);
    check("flush_done", 32'(bus.done), 32'h0);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    check("flush_state", 32'(bus.dbg_state), 32'(IDLE));
    check("flush_stall_after", 32'(bus.stall), 32'h0);
    run_op(mul, 32'd123, 32'd456, 1'b0);

    // flush landing on the done cycle suppresses the pulse
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = div; bus.rs1_v = 32'd5; bus.rs2_v = 32'd0;
    @(posedge clk); #1;
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_done_cycle", 32'(bus.done), 32'h0);
    check("flush_done_result", bus.result, 32'h0);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    check("flush_done_state", 32'(bus.dbg_state), 32'(IDLE));

    // reset mid-CALC
    @(posedge clk); #1;
    bus.start = 1'b1; bus.funct3 = divu; bus.rs1_v = 32'd1000; bus.rs2_v = 32'd3;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1; bus.start = 1'b0;
    @(negedge clk);
    check("mid_rst_stall", 32'(bus.stall), 32'h0);
    check("mid_rst_done", 32'(bus.done), 32'h0);
    check("mid_rst_result", bus.result, 32'h0);
    check("mid_rst_state", 32'(bus.dbg_state), 32'(IDLE));
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // back-to-back MUL then DIV with operands changing during CALC
    run_op(mul, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    run_op(div, 32'hF000_0001, 32'h0000_0013, 1'b1);

    for (int n = 0; n < 150; n++) begin
      run_op(muldiv_f3_t'($urandom_range(0, 7)), pick(), pick(), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL leftover_expect: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
